ark_round_stage: RTL

Registered AddRoundKey stage that sits directly downstream of the MixColumns block. It consumes the 128-bit MixColumns state over a valid/ready handshake, XORs it with the round key selected by an internal round counter, and presents the result through a 2-entry output buffer. The MixColumns field-mode select (`indx`) travels with each beat as sideband. Round keys are loaded through a write port into an on-block key store.

---
 rtl/ark_round_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ark_round_stage.sv
`default_nettype none
// ============================================================================
// Module   : ark_round_stage
// Purpose  : AddRoundKey stage after MixColumns; XORs each beat with the key
//            of the current round and queues it in a 2-entry output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module ark_round_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_we,
  input  logic [3:0]   key_addr,
  input  logic [127:0] key_wdata,
  output logic         key_err,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_indx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_indx,
  output logic [3:0]   out_round,
  output logic         out_last
);

  localparam logic [3:0] c_nr = 4'(NR);

  logic [127:0] r_key [0:NR];
  logic         r_key_err;
  logic [3:0]   r_rnd;
  logic [1:0]   r_count;

  logic [127:0] r_h_data;
  logic         r_h_indx;
  logic [3:0]   r_h_round;
  logic         r_h_last;
  logic [127:0] r_t_data;
  logic         r_t_indx;
  logic [3:0]   r_t_round;
  logic         r_t_last;

  logic         w_push;
  logic         w_pop;
  logic [127:0] w_new_data;
  logic         w_new_last;

  // Each key register decodes its own address, so out-of-range writes hit nothing.
  generate
    for (genvar k = 0; k <= NR; k++) begin : g_key
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_key[k] <= '0;
        end else if (key_we && (key_addr == 4'(k))) begin
          r_key[k] <= key_wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_err <= 1'b0;
    end else begin
      r_key_err <= key_we && (key_addr > c_nr);
    end
  end

  assign in_ready   = (r_count != 2'd2) && !flush;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_count != 2'd0) && out_ready;
  assign w_new_data = in_data ^ r_key[r_rnd];
  assign w_new_last = (r_rnd == c_nr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd     <= '0;
      r_count   <= '0;
      r_h_data  <= '0;
      r_h_indx  <= 1'b0;
      r_h_round <= '0;
      r_h_last  <= 1'b0;
      r_t_data  <= '0;
      r_t_indx  <= 1'b0;
      r_t_round <= '0;
      r_t_last  <= 1'b0;
    end else if (flush) begin
      r_rnd   <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_rnd <= w_new_last ? 4'd0 : r_rnd + 4'd1;
      end
      case ({w_push, w_pop})
        // Only reachable at count 1: the new beat replaces the departing head.
        2'b11: begin
          r_h_data  <= w_new_data;
          r_h_indx  <= in_indx;
          r_h_round <= r_rnd;
          r_h_last  <= w_new_last;
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_h_data  <= w_new_data;
            r_h_indx  <= in_indx;
            r_h_round <= r_rnd;
            r_h_last  <= w_new_last;
          end else begin
            r_t_data  <= w_new_data;
            r_t_indx  <= in_indx;
            r_t_round <= r_rnd;
            r_t_last  <= w_new_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_h_data  <= r_t_data;
          r_h_indx  <= r_t_indx;
          r_h_round <= r_t_round;
          r_h_last  <= r_t_last;
          r_count   <= r_count - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign key_err   = r_key_err;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_h_data;
  assign out_indx  = r_h_indx;
  assign out_round = r_h_round;
  assign out_last  = r_h_last;

endmodule
`default_nettype wire
